// File: rtl/fixed_priority.sv
// Fixed-priority arbiter: bit 0 wins, grant is the registered lowest set bit of req.
// Pure arbitration with no fairness or memory; the grant register is the only state.
module fixed_priority #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [N-1:0] next_grant;
    logic         higher;

    // Walk from the top-priority bit down; a bit wins only if no lower index is requesting.
    always_comb begin
        next_grant = '0;
        higher     = 1'b0;
        for (int i = 0; i < N; i++) begin
            next_grant[i] = req[i] & ~higher;
            higher        = higher | req[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= '0;
        end else begin
            grant <= next_grant;
        end
    end

endmodule

// File: tb/tb_fixed_priority.sv
// Directed and sweep checks for the fixed-priority arbiter with immediate assertions.
module tb_fixed_priority;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;

    int checks = 0;
    int passed = 0;

    fixed_priority #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: isolate the lowest set bit via two's complement.
    function automatic logic [N-1:0] lowestBit(input logic [N-1:0] v);
        logic [N-1:0] t;
        t = v;
        return t & (~t + 4'd1);
    endfunction

    task automatic applyStimulus(input logic [N-1:0] v);
        req = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] expected);
        checks++;
        assert (grant === expected) passed++;
        else $error("[TB] FAIL %s: grant=%b expected=%b", tag, grant, expected);
    endtask

    task automatic checkOneHot(input string tag);
        checks++;
        assert ($countones(grant) <= 1) passed++;
        else $error("[TB] FAIL %s: grant=%b has more than one bit set", tag, grant);
    endtask

    initial begin
        logic [N-1:0] v;

        rst = 1'b1;
        req = 4'b1111;
        #2;
        checkOutput("reset_async", 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 4'b0000);
        #14;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_eval", 4'b0001);

        applyStimulus(4'b1100); checkOutput("enc_1100", 4'b0100);
        applyStimulus(4'b1010); checkOutput("enc_1010", 4'b0010);
        applyStimulus(4'b1000); checkOutput("enc_1000", 4'b1000);
        applyStimulus(4'b0110); checkOutput("enc_0110", 4'b0010);

        applyStimulus(4'b0000); checkOutput("idle", 4'b0000);
        req = 4'b0001;
        #1;
        checkOutput("no_comb_path", 4'b0000);
        applyStimulus(4'b0001); checkOutput("idle_exit", 4'b0001);

        applyStimulus(4'b1000); checkOutput("pre_hold", 4'b1000);
        applyStimulus(4'b1001); checkOutput("preempt", 4'b0001);
        applyStimulus(4'b1000); checkOutput("preempt_drop", 4'b1000);

        applyStimulus(4'b0100); checkOutput("mid_setup", 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_async", 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("mid_held", 4'b0000);
        rst = 1'b0;
        applyStimulus(4'b0100); checkOutput("mid_resume", 4'b0100);

        for (int i = 0; i < 16; i++) begin
            v = i[N-1:0];
            applyStimulus(v);
            checkOutput("sweep", lowestBit(v));
            checkOneHot("sweep_onehot");
        end

        for (int i = 0; i < 200; i++) begin
            v = N'($urandom_range(0, 15));
            applyStimulus(v);
            checkOutput("random", lowestBit(v));
            checkOneHot("random_onehot");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fixed_priority.md
Name: fixed_priority

Overview:
- Fixed-priority arbiter for N requesters (default 4) with a registered one-hot grant.
- Bit 0 has the highest priority; priority falls with increasing index.
- Sits between a set of requesting agents and a shared resource. Grant is re-evaluated every clock with no fairness, locking or memory of previous winners.

Parameters:
- N, 4, number of requesters; width of req and grant; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- grant  output  N  registered one-hot (or all-zero) grant vector; bit i high means requester i owns the resource this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset:
  - While rst=1, grant=0 immediately, with no clock edge required. It holds 0 for as long as rst is asserted.
  - First evaluation happens on the first rising clk edge after rst deasserts.
- Arbitration function:
  - next_grant[i] = req[i] AND NOT(req[0] OR ... OR req[i-1]).
  - next_grant[0] = req[0].
  - The result is the isolated lowest set bit of req.
- Timing:
  - grant <= next_grant on every rising clk edge when rst=0.
  - Latency is exactly 1 cycle from req sample to grant. grant is never driven combinationally from req.
- One-hot guarantee: grant has at most one bit set at all times. popcount(grant) <= 1.
- No requests: req=0 gives grant=0 on the next edge.
- Starvation: a lower-priority requester receives no grant while any higher-priority bit stays set. This is intended.
- No handshake or hold:
  - A granted requester keeps grant only while it remains the highest-priority active request at each edge.
  - Dropping req removes grant on the next edge.
  - A higher-priority req arriving preempts on the next edge.
- Unknown inputs: if req contains X/Z, grant may be X. Requesters must drive req to a known value once reset deasserts.
- Reset mid-operation: asserting rst at any time forces grant=0 asynchronously. Arbitration resumes one edge after release.
- No internal state other than the grant register.

Test Plan:
- Reset: rst=1 with req=4'b1111 -> grant=4'b0000 throughout. rst drops at 20 ns; the edge at 25 ns samples req=4'b1111 -> grant=4'b0001.
- Priority encode, one vector per cycle (grant appears after the next rising edge):
  - req=4'b1100 -> grant=4'b0100
  - req=4'b1010 -> grant=4'b0010
  - req=4'b1000 -> grant=4'b1000
  - req=4'b0110 -> grant=4'b0010
- Idle: req=4'b0000 -> grant=4'b0000 on the next edge. Then req=4'b0001 -> grant=4'b0001 exactly one edge later.
- Preemption: hold req=4'b1000 (grant=4'b1000), then raise req=4'b1001 -> grant=4'b0001 on the next edge. Drop bit 0 (req=4'b1000) -> grant=4'b1000 one edge later.
- Async reset mid-run: with grant=4'b0100, assert rst between edges -> grant=0 before the next edge. Release with req=4'b0100 -> grant=4'b0100 after the next edge.
- Exhaustive random: apply all 16 req values and 200 random cycles. Check every cycle: grant == isolated lowest set bit of the previous-cycle req, and popcount(grant) <= 1.
